// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store engine: lane alignment, byte enables, load extension, misalign/timeout flags
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                is_store,
  input  logic [1:0]          size,
  input  logic                unsigned_ld,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [XLEN-1:0]     wdata,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     rdata,
  output logic                err_misaligned,
  output logic                err_timeout,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ack
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [OFFW-1:0]   op_off, op_off_nxt;
  logic [1:0]        op_size, op_size_nxt;
  logic              op_uns, op_uns_nxt;

  logic              busy_nxt, done_nxt, err_mis_nxt, err_to_nxt;
  logic              mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [NB-1:0]     mem_be_nxt;
  logic [XLEN-1:0]   mem_wdata_nxt, rdata_nxt;

  logic [OFFW-1:0]   off;
  logic              misaligned;
  logic              timed_out;
  logic [NB-1:0]     be_calc;
  logic [XLEN-1:0]   ld_shift, ld_fmt;

  assign off       = addr[OFFW-1:0];
  assign timed_out = (cnt == CW'(TIMEOUT));
  assign ld_shift  = mem_rdata >> {op_off, 3'b000};

  // A double access on a 32-bit build has no legal form, so it is rejected like a misalignment.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      2'b11:   misaligned = (XLEN == 32) ? 1'b1 : |addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    be_calc = '1;
    case (size)
      2'b00:   be_calc = NB'(1) << off;
      2'b01:   be_calc = NB'(3) << off;
      2'b10:   be_calc = NB'(15) << off;
      default: be_calc = '1;
    endcase
  end

  always_comb begin
    ld_fmt = ld_shift;
    case (op_size)
      2'b00:   for (int i = 8;  i < XLEN; i++) ld_fmt[i] = ~op_uns & ld_shift[7];
      2'b01:   for (int i = 16; i < XLEN; i++) ld_fmt[i] = ~op_uns & ld_shift[15];
      2'b10:   for (int i = 32; i < XLEN; i++) ld_fmt[i] = ~op_uns & ld_shift[31];
      default: ld_fmt = ld_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      op_off         <= '0;
      op_size        <= '0;
      op_uns         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      rdata          <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_be         <= '0;
      mem_wdata      <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      op_off         <= op_off_nxt;
      op_size        <= op_size_nxt;
      op_uns         <= op_uns_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      err_misaligned <= err_mis_nxt;
      err_timeout    <= err_to_nxt;
      rdata          <= rdata_nxt;
      mem_req        <= mem_req_nxt;
      mem_we         <= mem_we_nxt;
      mem_addr       <= mem_addr_nxt;
      mem_be         <= mem_be_nxt;
      mem_wdata      <= mem_wdata_nxt;
    end
  end

  // An ack in the final allowed cycle still completes the access rather than timing out.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = misaligned ? DONE : REQ;
      REQ:     if (mem_ack || timed_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
    err_mis_nxt   = 1'b0;
    err_to_nxt    = 1'b0;
    cnt_nxt       = cnt;
    op_off_nxt    = op_off;
    op_size_nxt   = op_size;
    op_uns_nxt    = op_uns;
    rdata_nxt     = rdata;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_be_nxt    = mem_be;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (start) begin
          if (misaligned) begin
            err_mis_nxt = 1'b1;
          end else begin
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = is_store;
            mem_addr_nxt  = {addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            mem_be_nxt    = be_calc;
            mem_wdata_nxt = wdata << {off, 3'b000};
            cnt_nxt       = '0;
            op_off_nxt    = off;
            op_size_nxt   = size;
            op_uns_nxt    = unsigned_ld;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          if (!mem_we) rdata_nxt = ld_fmt;
        end else if (timed_out) begin
          mem_req_nxt = 1'b0;
          err_to_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
